// File: rtl/beacon_sweep.sv
// Acquisition sweep controller: steps the correlator shift over 0..255, dwells at each
// shift, and keeps the first-seen peak match count, its shift, and a threshold lock flag.
module beacon_sweep #(
  parameter int unsigned DWELL = 514
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] step,
  input  logic [7:0] threshold,
  input  logic [7:0] corr_value,
  output logic       corr_rst,
  output logic [7:0] corr_shift,
  output logic       busy,
  output logic       done,
  output logic [7:0] peak_value,
  output logic [7:0] peak_shift,
  output logic       lock,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DWELL  = 3'd2,
    S_SAMPLE = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [15:0] DWELL_INIT = 16'(DWELL - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cur_shift_q, cur_shift_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  thr_q, thr_d;
  logic [7:0]  peak_value_q, peak_value_d;
  logic [7:0]  peak_shift_q, peak_shift_d;
  logic        lock_q, lock_d;
  logic [8:0]  sum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      cur_shift_q  <= 8'd0;
      step_q       <= 8'd1;
      thr_q        <= 8'd0;
      peak_value_q <= 8'd0;
      peak_shift_q <= 8'd0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_shift_q  <= cur_shift_d;
      step_q       <= step_d;
      thr_q        <= thr_d;
      peak_value_q <= peak_value_d;
      peak_shift_q <= peak_shift_d;
      lock_q       <= lock_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_shift_d  = cur_shift_q;
    step_d       = step_q;
    thr_d        = thr_q;
    peak_value_d = peak_value_q;
    peak_shift_d = peak_shift_q;
    lock_d       = lock_q;
    corr_rst     = 1'b1;
    // Carry out of the 9-bit sum means the next shift would wrap past 255.
    sum          = {1'b0, cur_shift_q} + {1'b0, step_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d       = (step == 8'd0) ? 8'd1 : step;
          thr_d        = threshold;
          cur_shift_d  = 8'd0;
          peak_value_d = 8'd0;
          peak_shift_d = 8'd0;
          lock_d       = 1'b0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = DWELL_INIT;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        corr_rst = 1'b0;
        if (cnt_q == 16'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SAMPLE: begin
        corr_rst = 1'b0;
        // Strict compare keeps the lowest shift among equal peaks.
        if (corr_value > peak_value_q) begin
          peak_value_d = corr_value;
          peak_shift_d = cur_shift_q;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (sum[8]) begin
          state_d = S_DONE;
        end else begin
          cur_shift_d = sum[7:0];
          state_d     = S_LOAD;
        end
      end
      S_DONE: begin
        lock_d  = (peak_value_q >= thr_q);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign corr_shift = cur_shift_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign peak_value = peak_value_q;
  assign peak_shift = peak_shift_q;
  assign lock       = lock_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_beacon_sweep.sv
// Bench for beacon_sweep: a table-driven correlator model feeds corr_value, and a
// sweep reference (visited shifts, peak, lock, done cycle) is computed from the sweep rules.
module tb_beacon_sweep;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] step = 8'd0;
  logic [7:0] threshold = 8'd0;
  logic [7:0] corr_value;
  logic       corr_rst;
  logic [7:0] corr_shift;
  logic       busy;
  logic       done;
  logic [7:0] peak_value;
  logic [7:0] peak_shift;
  logic       lock;
  logic [2:0] dbg_state;

  logic [7:0] tab [256];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference results
  logic [7:0]  exp_q[$];
  int unsigned exp_sig;
  int          exp_done;
  logic [7:0]  exp_peak, exp_pshift;
  logic        exp_lock;

  // Observed sweep results
  logic [7:0]  got_q[$];
  int unsigned got_sig;
  int          got_done, dwell_bad, busy_bad, clear_bad;

  beacon_sweep #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .threshold(threshold),
    .corr_value(corr_value), .corr_rst(corr_rst), .corr_shift(corr_shift),
    .busy(busy), .done(done), .peak_value(peak_value), .peak_shift(peak_shift),
    .lock(lock), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign corr_value = tab[corr_shift];

  task automatic clear_tab();
    for (int i = 0; i < 256; i++) tab[i] = 8'd0;
  endtask

  task automatic basic_tab();
    clear_tab();
    tab[0] = 8'd10; tab[64] = 8'd40; tab[128] = 8'd25; tab[192] = 8'd5;
  endtask

  // Reference: visit k*s for every k*s <= 255, keep the first maximum.
  task automatic model(input logic [7:0] st, input logic [7:0] th);
    int s;
    s = (st == 8'd0) ? 1 : int'(st);
    exp_q.delete();
    exp_sig = 0; exp_peak = 8'd0; exp_pshift = 8'd0;
    for (int v = 0; v <= 255; v += s) begin
      exp_q.push_back(8'(v));
      exp_sig = exp_sig * 31 + v + 1;
      if (tab[v] > exp_peak) begin
        exp_peak = tab[v];
        exp_pshift = 8'(v);
      end
    end
    exp_lock = (exp_peak >= th);
    exp_done = exp_q.size() * (DW + 3) + 1;
  endtask

  // Launches a sweep from an IDLE cycle (cycle 0) and returns in the done cycle.
  task automatic do_sweep(input logic [7:0] st, input logic [7:0] th, input bit hold,
                          input int pulse_cyc);
    logic prev_rst;
    int   run;
    step = st; threshold = th; start = 1'b1;
    got_q.delete(); got_sig = 0; got_done = -1;
    dwell_bad = 0; busy_bad = 0; clear_bad = 0;
    prev_rst = corr_rst; run = 0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(posedge clk); #1;
      if (!hold) start = (cyc == pulse_cyc);
      if (cyc == 1) begin
        if (peak_value !== 8'd0 || peak_shift !== 8'd0 || lock !== 1'b0) clear_bad++;
        step = 8'($urandom); threshold = 8'($urandom);
      end
      if (busy !== 1'b1) busy_bad++;
      if (!corr_rst) begin
        if (prev_rst) begin
          got_q.push_back(corr_shift);
          got_sig = got_sig * 31 + 32'(corr_shift) + 1;
        end
        run++;
      end else begin
        if (!prev_rst && run != DW + 1) dwell_bad++;
        run = 0;
      end
      prev_rst = corr_rst;
      if (done === 1'b1) begin
        got_done = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (corr_rst !== 1'b1) $display("FAIL reset_corr_rst got=%0b exp=1", corr_rst); else n_pass++;
    n_checks++; if (corr_shift !== 8'd0) $display("FAIL reset_corr_shift got=%0d exp=0", corr_shift); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
    n_checks++; if (peak_value !== 8'd0) $display("FAIL reset_peak_value got=%0d exp=0", peak_value); else n_pass++;
    n_checks++; if (peak_shift !== 8'd0) $display("FAIL reset_peak_shift got=%0d exp=0", peak_shift); else n_pass++;
    n_checks++; if (lock !== 1'b0) $display("FAIL reset_lock got=%0b exp=0", lock); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || corr_rst !== 1'b1) $display("FAIL reset_idle busy=%0b corr_rst=%0b exp 0/1", busy, corr_rst); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] thr_list [3];
    logic       lock_list [3];
    thr_list = '{8'd30, 8'd41, 8'd40};
    lock_list = '{1'b1, 1'b0, 1'b1};
    basic_tab();
    for (int i = 0; i < 3; i++) begin
      model(8'd64, thr_list[i]);
      do_sweep(8'd64, thr_list[i], 1'b0, 0);
      n_checks++; if (got_done !== 29) $display("FAIL basic_done_cycle got=%0d exp=29", got_done); else n_pass++;
      n_checks++; if (got_q.size() !== 4 || got_sig !== exp_sig) $display("FAIL basic_shift_seq got_n=%0d exp_n=4 sig=%0h exp_sig=%0h", got_q.size(), got_sig, exp_sig); else n_pass++;
      n_checks++; if (dwell_bad !== 0) $display("FAIL basic_dwell_len bad_windows=%0d exp=0", dwell_bad); else n_pass++;
      n_checks++; if (busy_bad !== 0 || clear_bad !== 0) $display("FAIL basic_busy_clear busy_bad=%0d clear_bad=%0d exp=0", busy_bad, clear_bad); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (peak_value !== 8'd40 || peak_shift !== 8'd64) $display("FAIL basic_peak got=%0d@%0d exp=40@64", peak_value, peak_shift); else n_pass++;
      n_checks++; if (lock !== lock_list[i] || lock !== exp_lock) $display("FAIL basic_lock thr=%0d got=%0b exp=%0b", thr_list[i], lock, lock_list[i]); else n_pass++;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_after_done busy=%0b done=%0b exp=0/0", busy, done); else n_pass++;
    end
  endtask

  task automatic test_full_sweep();
    for (int i = 0; i < 256; i++) tab[i] = ~8'(i);
    model(8'd0, 8'd100);
    do_sweep(8'd0, 8'd100, 1'b0, 0);
    n_checks++; if (got_done !== 256 * (DW + 3) + 1 || got_done !== exp_done) $display("FAIL full_done_cycle got=%0d exp=%0d", got_done, 256 * (DW + 3) + 1); else n_pass++;
    n_checks++; if (got_q.size() !== 256 || got_sig !== exp_sig) $display("FAIL full_shift_seq got_n=%0d exp_n=256", got_q.size()); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (peak_value !== 8'd255 || peak_shift !== 8'd0) $display("FAIL full_peak got=%0d@%0d exp=255@0", peak_value, peak_shift); else n_pass++;
    n_checks++; if (lock !== 1'b1) $display("FAIL full_lock got=%0b exp=1", lock); else n_pass++;
  endtask

  task automatic test_ties_and_overflow();
    clear_tab();
    tab[0] = 8'd50; tab[128] = 8'd50;
    model(8'd128, 8'd50);
    do_sweep(8'd128, 8'd50, 1'b0, 0);
    n_checks++; if (got_q.size() !== 2 || got_sig !== exp_sig) $display("FAIL tie_shift_seq got_n=%0d exp_n=2", got_q.size()); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (peak_value !== 8'd50 || peak_shift !== 8'd0) $display("FAIL tie_peak got=%0d@%0d exp=50@0", peak_value, peak_shift); else n_pass++;
    n_checks++; if (lock !== 1'b1) $display("FAIL tie_lock_equal got=%0b exp=1", lock); else n_pass++;
    tab[200] = 8'd60;
    model(8'd200, 8'd0);
    do_sweep(8'd200, 8'd0, 1'b0, 0);
    n_checks++; if (got_done !== 2 * (DW + 3) + 1) $display("FAIL ovf_done_cycle got=%0d exp=%0d", got_done, 2 * (DW + 3) + 1); else n_pass++;
    n_checks++; if (got_q.size() !== 2 || got_sig !== exp_sig) $display("FAIL ovf_shift_seq got_n=%0d exp_n=2", got_q.size()); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (peak_value !== 8'd60 || peak_shift !== 8'd200) $display("FAIL ovf_peak got=%0d@%0d exp=60@200", peak_value, peak_shift); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int falls;
    bit hit;
    logic prev_rst;
    basic_tab();
    step = 8'd64; threshold = 8'd30; start = 1'b1;
    falls = 0; hit = 1'b0; prev_rst = corr_rst;
    for (int cyc = 1; cyc <= 200 && !hit; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (prev_rst && !corr_rst) falls++;
      prev_rst = corr_rst;
      if (falls == 2) hit = 1'b1;
    end
    n_checks++; if (!hit) $display("FAIL rstmid_reach_step2 got=timeout exp=second dwell"); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++; if (corr_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_ctrl corr_rst=%0b busy=%0b done=%0b exp=1/0/0", corr_rst, busy, done); else n_pass++;
    n_checks++; if (corr_shift !== 8'd0 || peak_value !== 8'd0 || peak_shift !== 8'd0 || lock !== 1'b0) $display("FAIL rstmid_vals shift=%0d peak=%0d@%0d lock=%0b exp all 0", corr_shift, peak_value, peak_shift, lock); else n_pass++;
    model(8'd64, 8'd30);
    do_sweep(8'd64, 8'd30, 1'b0, 0);
    n_checks++; if (got_done !== exp_done || got_sig !== exp_sig) $display("FAIL rstmid_resweep done=%0d exp=%0d n=%0d", got_done, exp_done, got_q.size()); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (peak_value !== exp_peak || peak_shift !== exp_pshift || lock !== exp_lock) $display("FAIL rstmid_result got=%0d@%0d lock=%0b exp=%0d@%0d lock=%0b", peak_value, peak_shift, lock, exp_peak, exp_pshift, exp_lock); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int pulses [2];
    pulses = '{3, 10};
    basic_tab();
    for (int i = 0; i < 2; i++) begin
      model(8'd64, 8'd30);
      do_sweep(8'd64, 8'd30, 1'b0, pulses[i]);
      n_checks++; if (got_done !== exp_done || got_q.size() !== exp_q.size() || got_sig !== exp_sig) $display("FAIL pulse_ignored at=%0d done=%0d exp=%0d n=%0d exp_n=%0d", pulses[i], got_done, exp_done, got_q.size(), exp_q.size()); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    basic_tab();
    model(8'd64, 8'd30);
    do_sweep(8'd64, 8'd30, 1'b1, 0);
    n_checks++; if (got_done !== exp_done) $display("FAIL b2b_first_done got=%0d exp=%0d", got_done, exp_done); else n_pass++;
    for (int i = 0; i < 256; i++) tab[i] = 8'd5;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || lock !== 1'b1) $display("FAIL b2b_idle_gap busy=%0b done=%0b lock=%0b exp=0/0/1", busy, done, lock); else n_pass++;
    model(8'd64, 8'd200);
    do_sweep(8'd64, 8'd200, 1'b1, 0);
    start = 1'b0;
    n_checks++; if (got_done !== exp_done) $display("FAIL b2b_second_done got=%0d exp=%0d", got_done, exp_done); else n_pass++;
    n_checks++; if (clear_bad !== 0) $display("FAIL b2b_restart_clear bad=%0d exp=0", clear_bad); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (peak_value !== 8'd5 || peak_shift !== 8'd0 || lock !== 1'b0) $display("FAIL b2b_second_result got=%0d@%0d lock=%0b exp=5@0 lock=0", peak_value, peak_shift, lock); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_stops busy=%0b exp=0", busy); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] st, th;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 256; i++) tab[i] = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(9, 255));
      th = 8'($urandom_range(0, 255));
      model(st, th);
      do_sweep(st, th, 1'b0, 0);
      n_checks++; if (got_done !== exp_done || got_sig !== exp_sig) $display("FAIL rand_seq step=%0d done=%0d exp=%0d n=%0d exp_n=%0d", st, got_done, exp_done, got_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (dwell_bad !== 0 || busy_bad !== 0 || clear_bad !== 0) $display("FAIL rand_timing step=%0d dwell_bad=%0d busy_bad=%0d clear_bad=%0d exp=0", st, dwell_bad, busy_bad, clear_bad); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (peak_value !== exp_peak || peak_shift !== exp_pshift || lock !== exp_lock) $display("FAIL rand_result step=%0d thr=%0d got=%0d@%0d lock=%0b exp=%0d@%0d lock=%0b", st, th, peak_value, peak_shift, lock, exp_peak, exp_pshift, exp_lock); else n_pass++;
    end
  endtask

  initial begin
    clear_tab();
    test_reset();
    test_basic();
    test_full_sweep();
    test_ties_and_overflow();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
